glb_bus_scheduler: RTL and testbench

Sequences global-buffer traffic onto the shared GLB-to-PE multicast bus for one convolution job.
- For each PE column tag in turn, it streams a filter row, then an ifmap row, then one partial sum onto the bus.
- It drives TAG, CASTER_EN and kernel_size, and throttles on the bus READY.
- It sits between the GLB read ports (three valid/ready streams) and the bus interface consumed by the PE array.

---
 rtl/glb_bus_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_glb_bus_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_bus_scheduler.sv
// glb_bus_scheduler: sequences filter, ifmap and psum traffic from the GLB
// read ports onto the shared GLB-to-PE multicast bus, one column tag at a time.
// For each tag it sends K filter beats, then K ifmap beats, then one psum beat.
module glb_bus_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  cfg_kernel_size,
    input  logic                        fltr_valid,
    output logic                        fltr_ready,
    input  logic [DATA_WIDTH-1:0]       fltr_data,
    input  logic                        ifmap_valid,
    output logic                        ifmap_ready,
    input  logic [DATA_WIDTH-1:0]       ifmap_data,
    input  logic                        psum_valid,
    output logic                        psum_ready,
    input  logic [2*DATA_WIDTH-1:0]     psum_data,
    input  logic                        bus_ready,
    output logic [DATA_WIDTH-1:0]       bus_fltr_data,
    output logic [DATA_WIDTH-1:0]       bus_ifmap_data,
    output logic [2*DATA_WIDTH-1:0]     bus_psum_data,
    output logic [$clog2(NUM_COL)-1:0]  bus_tag,
    output logic                        bus_en,
    output logic [7:0]                  bus_kernel_size,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int TAG_W = $clog2(NUM_COL);
    localparam logic [TAG_W-1:0] LAST_COL = TAG_W'(NUM_COL - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLTR  = 3'd1,
        ST_IFMAP = 3'd2,
        ST_PSUM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TAG_W-1:0]        col_cnt_q, col_cnt_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [7:0]              ksize_q, ksize_d;
    logic [DATA_WIDTH-1:0]   fltr_word_q, fltr_word_d;
    logic [DATA_WIDTH-1:0]   ifmap_word_q, ifmap_word_d;
    logic [2*DATA_WIDTH-1:0] psum_word_q, psum_word_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic fltr_acc_s;
    logic ifmap_acc_s;
    logic psum_acc_s;
    logic last_beat_s;

    // Only the source owned by the current phase may see the bus READY.
    assign fltr_ready  = (state_q == ST_FLTR)  && bus_ready;
    assign ifmap_ready = (state_q == ST_IFMAP) && bus_ready;
    assign psum_ready  = (state_q == ST_PSUM)  && bus_ready;

    assign fltr_acc_s  = fltr_valid  && fltr_ready;
    assign ifmap_acc_s = ifmap_valid && ifmap_ready;
    assign psum_acc_s  = psum_valid  && psum_ready;

    // K is never 0 inside a job, so K-1 cannot underflow here.
    assign last_beat_s = (beat_cnt_q == (ksize_q - 8'd1));

    // Next-state, counter and bus-register computation for the whole scheduler.
    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        ksize_d      = ksize_q;
        fltr_word_d  = fltr_word_q;
        ifmap_word_d = ifmap_word_q;
        psum_word_d  = psum_word_q;
        tag_d        = tag_q;
        en_d         = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_kernel_size != 8'd0) begin
                        ksize_d    = cfg_kernel_size;
                        col_cnt_d  = '0;
                        beat_cnt_d = 8'd0;
                        busy_d     = 1'b1;
                        state_d    = ST_FLTR;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FLTR: begin
                if (fltr_acc_s) begin
                    fltr_word_d = fltr_data;
                    en_d        = 1'b1;
                    tag_d       = col_cnt_q;
                    if (last_beat_s) begin
                        beat_cnt_d = 8'd0;
                        state_d    = ST_IFMAP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_FLTR;
                end
            end

            ST_IFMAP: begin
                if (ifmap_acc_s) begin
                    ifmap_word_d = ifmap_data;
                    en_d         = 1'b1;
                    tag_d        = col_cnt_q;
                    if (last_beat_s) begin
                        beat_cnt_d = 8'd0;
                        state_d    = ST_PSUM;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_IFMAP;
                end
            end

            ST_PSUM: begin
                if (psum_acc_s) begin
                    psum_word_d = psum_data;
                    en_d        = 1'b1;
                    tag_d       = col_cnt_q;
                    if (col_cnt_q == LAST_COL) begin
                        // done and busy drop land together with the final bus_en.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        col_cnt_d = col_cnt_q + TAG_W'(1);
                        state_d   = ST_FLTR;
                    end
                end else begin
                    state_d = ST_PSUM;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and abandons any job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_cnt_q    <= '0;
            beat_cnt_q   <= 8'd0;
            ksize_q      <= 8'd0;
            fltr_word_q  <= '0;
            ifmap_word_q <= '0;
            psum_word_q  <= '0;
            tag_q        <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            ksize_q      <= ksize_d;
            fltr_word_q  <= fltr_word_d;
            ifmap_word_q <= ifmap_word_d;
            psum_word_q  <= psum_word_d;
            tag_q        <= tag_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus_fltr_data   = fltr_word_q;
    assign bus_ifmap_data  = ifmap_word_q;
    assign bus_psum_data   = psum_word_q;
    assign bus_tag         = tag_q;
    assign bus_en          = en_q;
    assign bus_kernel_size = ksize_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_glb_bus_scheduler.sv
// Directed bench for glb_bus_scheduler: source models hand out numbered words,
// and a position-based model predicts the F..F,I..I,P order and tag per beat.
module tb_glb_bus_scheduler;

    localparam int DW = 16;
    localparam int NC = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    cfg_kernel_size;
    logic          fltr_valid, fltr_ready;
    logic [DW-1:0] fltr_data;
    logic          ifmap_valid, ifmap_ready;
    logic [DW-1:0] ifmap_data;
    logic          psum_valid, psum_ready;
    logic [2*DW-1:0] psum_data;
    logic          bus_ready;
    logic [DW-1:0] bus_fltr_data;
    logic [DW-1:0] bus_ifmap_data;
    logic [2*DW-1:0] bus_psum_data;
    logic [1:0]    bus_tag;
    logic          bus_en;
    logic [7:0]    bus_kernel_size;
    logic          busy, done, err;

    glb_bus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_kernel_size(cfg_kernel_size),
        .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .bus_ready(bus_ready), .bus_fltr_data(bus_fltr_data),
        .bus_ifmap_data(bus_ifmap_data), .bus_psum_data(bus_psum_data),
        .bus_tag(bus_tag), .bus_en(bus_en), .bus_kernel_size(bus_kernel_size),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad;
    int k_cur, nbeats, ndone, nerr, nbusy, seq_err, ready_err;
    int exp_pos, exp_tag, exp_f, exp_i, exp_p;
    int f_n, i_n, p_n, cyc_no, first_en;
    bit f_acc, i_acc, p_acc;

    // Clear per-job scoreboard state and rewind the numbered sources.
    task begin_job(input int k);
        k_cur = k; nbeats = 0; ndone = 0; nerr = 0; nbusy = 0;
        seq_err = 0; ready_err = 0; exp_pos = 0; exp_tag = 0;
        exp_f = 0; exp_i = 0; exp_p = 0; f_n = 0; i_n = 0; p_n = 0;
        cyc_no = 0; first_en = -1;
        fltr_data  = 16'h1000;
        ifmap_data = 16'h2000;
        psum_data  = 32'h3000_0000;
    endtask

    task set_valid(input bit v);
        fltr_valid = v; ifmap_valid = v; psum_valid = v;
    endtask

    // One clock: note handshakes before the edge, score the bus after it.
    task cyc();
        #1;
        if (!bus_ready && (fltr_ready || ifmap_ready || psum_ready)) ready_err++;
        if ((int'(fltr_ready) + int'(ifmap_ready) + int'(psum_ready)) > 1) ready_err++;
        f_acc = fltr_valid && fltr_ready;
        i_acc = ifmap_valid && ifmap_ready;
        p_acc = psum_valid && psum_ready;
        @(posedge clk);
        #1;
        cyc_no++;
        if (busy === 1'b1) nbusy++;
        if (err === 1'b1) nerr++;
        if (bus_en === 1'b1) begin
            nbeats++;
            if (first_en < 0) first_en = cyc_no;
            if (exp_pos < k_cur) begin
                if (bus_fltr_data !== 16'(32'h1000 + exp_f)) seq_err++;
                exp_f++;
            end else if (exp_pos < 2 * k_cur) begin
                if (bus_ifmap_data !== 16'(32'h2000 + exp_i)) seq_err++;
                exp_i++;
            end else begin
                if (bus_psum_data !== 32'(32'h3000_0000 + exp_p)) seq_err++;
                exp_p++;
            end
            if (bus_tag !== 2'(exp_tag)) seq_err++;
            if (bus_kernel_size !== 8'(k_cur)) seq_err++;
            exp_pos++;
            if (exp_pos == 2 * k_cur + 1) begin
                exp_pos = 0;
                exp_tag++;
            end
        end
        if (done === 1'b1) begin
            ndone++;
            // done must coincide with the last beat and with busy low
            if (bus_en !== 1'b1 || busy !== 1'b0 || nbeats != NC * (2 * k_cur + 1)) seq_err++;
        end
        if (f_acc) begin f_n++; fltr_data  = 16'(32'h1000 + f_n); end
        if (i_acc) begin i_n++; ifmap_data = 16'(32'h2000 + i_n); end
        if (p_acc) begin p_n++; psum_data  = 32'(32'h3000_0000 + p_n); end
        @(negedge clk);
    endtask

    task start_job(input int k);
        start = 1'b1;
        cfg_kernel_size = 8'(k);
        cyc();
        start = 1'b0;
    endtask

    task run_until_done(input int budget, output bit ok);
        for (int c = 0; c < budget && ndone == 0; c++) cyc();
        ok = (ndone != 0);
        cyc();
        cyc();
    endtask

    task test_reset();
        rst = 1'b1; start = 1'b0; cfg_kernel_size = 8'd0; bus_ready = 1'b0;
        set_valid(1'b0);
        begin_job(0);
        #3;
        total++;
        if ({bus_en, busy, done, err, fltr_ready, ifmap_ready, psum_ready} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000000",
                {bus_en, busy, done, err, fltr_ready, ifmap_ready, psum_ready});
        end
        total++;
        if ({bus_fltr_data, bus_ifmap_data, bus_psum_data, bus_tag, bus_kernel_size} !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0",
                {bus_fltr_data, bus_ifmap_data, bus_psum_data, bus_tag, bus_kernel_size});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task test_basic();
        bit ok;
        begin_job(3); set_valid(1'b1); bus_ready = 1'b1;
        start_job(3);
        run_until_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
        total++; if (nbeats != 28) begin bad++; $display("FAIL basic_beats got=%0d want=28", nbeats); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL basic_order got=%0d want=0", seq_err); end
        total++; if (ndone != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", ndone); end
        // busy rises the cycle after start and falls with done: one per accept cycle
        total++; if (nbusy != 28) begin bad++; $display("FAIL basic_busy got=%0d want=28", nbusy); end
        total++; if (first_en != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", first_en); end
        total++; if (nerr != 0 || ready_err != 0) begin
            bad++; $display("FAIL basic_err got=%0d/%0d want=0/0", nerr, ready_err); end
    endtask

    task test_backpressure();
        bit ok;
        begin_job(2); set_valid(1'b1); bus_ready = 1'b1;
        start_job(2);
        for (int c = 0; c < 400 && ndone == 0; c++) begin
            bus_ready = ~bus_ready;
            cyc();
        end
        ok = (ndone != 0);
        bus_ready = 1'b1;
        cyc(); cyc();
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=0 want=1"); end
        total++; if (ready_err != 0) begin bad++; $display("FAIL bp_ready got=%0d want=0", ready_err); end
        total++; if (nbeats != 20) begin bad++; $display("FAIL bp_beats got=%0d want=20", nbeats); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL bp_order got=%0d want=0", seq_err); end
        total++; if (ndone != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", ndone); end
    endtask

    task test_starvation();
        bit ok;
        int stall_bad;
        int c;
        stall_bad = 0;
        begin_job(4); set_valid(1'b1); bus_ready = 1'b1;
        start_job(4);
        for (c = 0; c < 300 && !(exp_tag == 1 && exp_pos == 5); c++) cyc();
        total++; if (!(exp_tag == 1 && exp_pos == 5)) begin
            bad++; $display("FAIL starve_reach got=%0d/%0d want=1/5", exp_tag, exp_pos); end
        ifmap_valid = 1'b0;
        for (int s = 0; s < 10; s++) begin
            cyc();
            if (bus_en !== 1'b0 || bus_tag !== 2'd1) stall_bad++;
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL starve_hold got=%0d want=0", stall_bad); end
        ifmap_valid = 1'b1;
        run_until_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL starve_timeout got=0 want=1"); end
        total++; if (nbeats != 36) begin bad++; $display("FAIL starve_beats got=%0d want=36", nbeats); end
        total++; if (seq_err != 0) begin bad++; $display("FAIL starve_order got=%0d want=0", seq_err); end
        total++; if (ndone != 1) begin bad++; $display("FAIL starve_done got=%0d want=1", ndone); end
    endtask

    task test_zero_kernel();
        bit ok;
        begin_job(0); set_valid(1'b1); bus_ready = 1'b1;
        start_job(0);
        total++; if (err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_err got=%b%b want=10", err, busy); end
        cyc(); cyc();
        total++; if (err !== 1'b0 || nerr != 1 || nbeats != 0 || nbusy != 0) begin
            bad++; $display("FAIL zero_after got=err%b n%0d beats%0d busy%0d want=0/1/0/0",
                err, nerr, nbeats, nbusy); end
        begin_job(1);
        start_job(1);
        run_until_done(100, ok);
        total++; if (!ok || nbeats != 12 || seq_err != 0 || ndone != 1) begin
            bad++; $display("FAIL zero_k1 got=ok%0d beats%0d seq%0d done%0d want=1/12/0/1",
                ok, nbeats, seq_err, ndone); end
    endtask

    task test_reset_midjob();
        bit ok;
        begin_job(5); set_valid(1'b1); bus_ready = 1'b1;
        start_job(5);
        for (int c = 0; c < 300 && !(exp_tag == 2 && exp_pos == 3); c++) cyc();
        total++; if (!(exp_tag == 2 && exp_pos == 3)) begin
            bad++; $display("FAIL rstmid_reach got=%0d/%0d want=2/3", exp_tag, exp_pos); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_en, busy, done, err, fltr_ready, ifmap_ready, psum_ready, bus_tag,
             bus_kernel_size, bus_fltr_data, bus_ifmap_data, bus_psum_data} !== '0) begin
            bad++; $display("FAIL rstmid_async got=%b%b%b%b tag%0d k%0d want=0",
                bus_en, busy, done, err, bus_tag, bus_kernel_size);
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || bus_en !== 1'b0 || ndone != 0) begin
            bad++; $display("FAIL rstmid_nodone got=%b%b/%0d want=00/0", done, bus_en, ndone); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        begin_job(1);
        start_job(1);
        run_until_done(100, ok);
        total++; if (!ok || nbeats != 12 || seq_err != 0 || ndone != 1 || exp_tag != 4) begin
            bad++; $display("FAIL rstmid_rerun got=ok%0d beats%0d seq%0d done%0d tags%0d want=1/12/0/1/4",
                ok, nbeats, seq_err, ndone, exp_tag); end
    endtask

    task test_start_busy();
        bit ok;
        begin_job(3); set_valid(1'b1); bus_ready = 1'b1;
        start_job(3);
        for (int c = 0; c < 200 && !(exp_tag == 1 && exp_pos == 1); c++) cyc();
        start = 1'b1;
        cfg_kernel_size = 8'd9;
        cyc();
        start = 1'b0;
        total++; if (bus_kernel_size !== 8'd3 || err !== 1'b0) begin
            bad++; $display("FAIL busy_start got=k%0d err%b want=k3 err0", bus_kernel_size, err); end
        run_until_done(200, ok);
        total++; if (!ok || nbeats != 28 || seq_err != 0 || ndone != 1 || nerr != 0) begin
            bad++; $display("FAIL busy_job got=ok%0d beats%0d seq%0d done%0d err%0d want=1/28/0/1/0",
                ok, nbeats, seq_err, ndone, nerr); end
    endtask

    task test_max_kernel();
        bit ok;
        begin_job(255); set_valid(1'b1); bus_ready = 1'b1;
        start_job(255);
        run_until_done(3000, ok);
        total++; if (!ok || nbeats != 2044 || seq_err != 0 || ndone != 1) begin
            bad++; $display("FAIL maxk_job got=ok%0d beats%0d seq%0d done%0d want=1/2044/0/1",
                ok, nbeats, seq_err, ndone); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_starvation();
        test_zero_kernel();
        test_reset_midjob();
        test_start_busy();
        test_max_kernel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
